// File: rtl/phase_commit_scheduler.sv
// Double-buffered phase bank: writes land in a shadow bank, and a commit copies
// the whole shadow bank into the active bank only at a PWM counter wrap.
//
// Ports:
//   clk, rst        PWM clock, asynchronous active-high reset
//   cnt             free-running PWM counter shared with the PWM channels
//   wr_valid/ready  phase write handshake (ready drops while a commit is pending)
//   wr_channel      target channel index
//   wr_phase        phase value
//   commit_req      strobe: shadow bank complete, schedule a commit
//   commit_pending  commit scheduled, not yet applied
//   commit_pulse    one-cycle strobe in the cycle the active bank updates
//   phases_flat     active bank, channel i at [i*CLK_CNT_W +: CLK_CNT_W]
//   overrun         sticky: commit_req while a commit was already pending
//   bad_channel     sticky: accepted write addressed a non-existent channel
//   overrun_cnt     saturating count of overrun events
//   frame_cnt       wrapping count of completed commits
module phase_commit_scheduler #(
   parameter int NUM_CHANNELS = 128,
   parameter int CLK_CNT_W    = 8,
   parameter int CLK_CNT_MAX  = 255,
   parameter int MIN_PERIODS  = 1,
   parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [CLK_CNT_W-1:0]              cnt,
   input  logic                              wr_valid,
   output logic                              wr_ready,
   input  logic [CH_W-1:0]                   wr_channel,
   input  logic [CLK_CNT_W-1:0]              wr_phase,
   input  logic                              commit_req,
   output logic                              commit_pending,
   output logic                              commit_pulse,
   output logic [NUM_CHANNELS*CLK_CNT_W-1:0] phases_flat,
   output logic                              overrun,
   output logic                              bad_channel,
   output logic [15:0]                       overrun_cnt,
   output logic [15:0]                       frame_cnt
);

   localparam int PS_W = (MIN_PERIODS > 1) ? $clog2(MIN_PERIODS) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(MIN_PERIODS - 1);
   localparam logic [CLK_CNT_W-1:0] CNT_WRAP = CLK_CNT_W'(CLK_CNT_MAX);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PENDING = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CLK_CNT_W-1:0] r_shadow [NUM_CHANNELS];
   logic [CLK_CNT_W-1:0] r_active [NUM_CHANNELS];
   logic [PS_W-1:0]      r_periods_since;
   logic                 r_pulse;
   logic                 r_overrun;
   logic                 r_bad;
   logic [15:0]          r_ovr_cnt;
   logic [15:0]          r_frame_cnt;

   logic w_wrap;
   logic w_wr_acc;
   logic w_ch_ok;
   logic w_commit;
   logic w_ovr_evt;

   // Exact match only: counter values past the terminal value never wrap.
   assign w_wrap   = (cnt == CNT_WRAP);
   assign w_wr_acc = wr_valid && (r_state == S_IDLE);
   assign w_ch_ok  = ({{(32-CH_W){1'b0}}, wr_channel} < 32'(NUM_CHANNELS));

   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      w_ovr_evt   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (commit_req) w_state_nxt = S_PENDING;
         end
         S_PENDING: begin
            // A request while pending is only counted, even in the commit cycle.
            w_ovr_evt = commit_req;
            if (w_wrap && (r_periods_since == PS_MAX)) begin
               w_commit    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_pulse         <= 1'b0;
         r_overrun       <= 1'b0;
         r_bad           <= 1'b0;
         r_ovr_cnt       <= '0;
         r_frame_cnt     <= '0;
         r_periods_since <= PS_MAX;
      end else begin
         r_state <= w_state_nxt;
         r_pulse <= w_commit;
         if (w_wr_acc && !w_ch_ok) r_bad <= 1'b1;
         if (w_ovr_evt) begin
            r_overrun <= 1'b1;
            if (r_ovr_cnt != 16'hFFFF) r_ovr_cnt <= r_ovr_cnt + 16'd1;
         end
         if (w_commit) begin
            r_frame_cnt     <= r_frame_cnt + 16'd1;
            r_periods_since <= '0;
         end else if (w_wrap && (r_periods_since != PS_MAX)) begin
            r_periods_since <= r_periods_since + 1'b1;
         end
      end
   end

   // Shadow is frozen while pending, so the copy always sees a complete frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         if (w_wr_acc && w_ch_ok) r_shadow[wr_channel] <= wr_phase;
         if (w_commit) r_active <= r_shadow;
      end
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_flat
      assign phases_flat[g*CLK_CNT_W +: CLK_CNT_W] = r_active[g];
   end

   assign wr_ready       = (r_state == S_IDLE);
   assign commit_pending = (r_state == S_PENDING);
   assign commit_pulse   = r_pulse;
   assign overrun        = r_overrun;
   assign bad_channel    = r_bad;
   assign overrun_cnt    = r_ovr_cnt;
   assign frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_phase_commit_scheduler.sv
// Bench for phase_commit_scheduler: two instances (default and 100ch/3-period
// holdoff/max 200) share stimulus and are compared to a frame-level model.
module tb_phase_commit_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] cnt;
   logic       wr_valid;
   logic [6:0] wr_channel;
   logic [7:0] wr_phase;
   logic       commit_req;

   logic         d0_rdy, d0_pend, d0_pulse, d0_ovr, d0_bad;
   logic [1023:0] d0_ph;
   logic [15:0]  d0_oc, d0_fc;
   logic         d1_rdy, d1_pend, d1_pulse, d1_ovr, d1_bad;
   logic [799:0] d1_ph;
   logic [15:0]  d1_oc, d1_fc;

   always #5 clk = ~clk;

   phase_commit_scheduler u_dut0 (
      .clk(clk), .rst(rst), .cnt(cnt),
      .wr_valid(wr_valid), .wr_ready(d0_rdy),
      .wr_channel(wr_channel), .wr_phase(wr_phase),
      .commit_req(commit_req), .commit_pending(d0_pend),
      .commit_pulse(d0_pulse), .phases_flat(d0_ph),
      .overrun(d0_ovr), .bad_channel(d0_bad),
      .overrun_cnt(d0_oc), .frame_cnt(d0_fc)
   );

   phase_commit_scheduler #(
      .NUM_CHANNELS(100), .CLK_CNT_W(8),
      .CLK_CNT_MAX(200), .MIN_PERIODS(3)
   ) u_dut1 (
      .clk(clk), .rst(rst), .cnt(cnt),
      .wr_valid(wr_valid), .wr_ready(d1_rdy),
      .wr_channel(wr_channel), .wr_phase(wr_phase),
      .commit_req(commit_req), .commit_pending(d1_pend),
      .commit_pulse(d1_pulse), .phases_flat(d1_ph),
      .overrun(d1_ovr), .bad_channel(d1_bad),
      .overrun_cnt(d1_oc), .frame_cnt(d1_fc)
   );

   int n_checks = 0;
   int n_errors = 0;

   int NCH[2]  = '{128, 100};
   int MINP[2] = '{1, 3};
   int CMAX[2] = '{255, 200};

   // Frame-level model: wraps counted since reset, commit allowed once
   // at least MINP wraps separate it from the previous commit.
   int     sh[2][128];
   int     ac[2][128];
   bit     pend[2], pul[2], ovr[2], bad[2];
   int     ovc[2], fc[2];
   longint wraps[2], last[2];
   longint ncyc = 0;
   int     p0 = 0, p1 = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 128; i++) begin
            sh[k][i] = 0;
            ac[k][i] = 0;
         end
         pend[k] = 0; pul[k] = 0; ovr[k] = 0; bad[k] = 0;
         ovc[k] = 0; fc[k] = 0;
         wraps[k] = 0;
         last[k] = 64'(1 - MINP[k]);
      end
   endtask

   task automatic mstep(input int k);
      bit p, wrap, cm;
      p    = pend[k];
      wrap = (int'(cnt) == CMAX[k]);
      cm   = p && wrap && ((wraps[k] + 1 - last[k]) >= 64'(MINP[k]));
      if (wrap) wraps[k]++;
      if (cm) begin
         last[k] = wraps[k];
         for (int i = 0; i < 128; i++) ac[k][i] = sh[k][i];
         fc[k] = (fc[k] + 1) % 65536;
         pend[k] = 0;
      end
      if (wr_valid && !p) begin
         if (int'(wr_channel) < NCH[k]) sh[k][wr_channel] = int'(wr_phase);
         else bad[k] = 1;
      end
      if (commit_req) begin
         if (p) begin
            ovr[k] = 1;
            if (ovc[k] < 65535) ovc[k]++;
         end else begin
            pend[k] = 1;
         end
      end
      pul[k] = cm;
   endtask

   task automatic chk_dut(input int k, input logic pd, input logic pu,
                          input logic ov, input logic bd,
                          input logic [15:0] oc, input logic [15:0] fcnt);
      check($sformatf("pend%0d", k), 64'(pd), 64'(pend[k]));
      check($sformatf("pulse%0d", k), 64'(pu), 64'(pul[k]));
      check($sformatf("ovr%0d", k), 64'(ov), 64'(ovr[k]));
      check($sformatf("bad%0d", k), 64'(bd), 64'(bad[k]));
      check($sformatf("ovc%0d", k), 64'(oc), 64'(ovc[k]));
      check($sformatf("fcnt%0d", k), 64'(fcnt), 64'(fc[k]));
   endtask

   task automatic check_all();
      int m0, m1;
      m0 = 0;
      m1 = 0;
      for (int i = 0; i < 128; i++)
         if (int'(d0_ph[i*8 +: 8]) != ac[0][i]) m0++;
      for (int i = 0; i < 100; i++)
         if (int'(d1_ph[i*8 +: 8]) != ac[1][i]) m1++;
      check("ph0_mism", 64'(m0), 64'd0);
      check("ph1_mism", 64'(m1), 64'd0);
      chk_dut(0, d0_pend, d0_pulse, d0_ovr, d0_bad, d0_oc, d0_fc);
      chk_dut(1, d1_pend, d1_pulse, d1_ovr, d1_bad, d1_oc, d1_fc);
   endtask

   task automatic drv(input logic v, input logic [6:0] ch,
                      input logic [7:0] ph, input logic r);
      wr_valid   = v;
      wr_channel = ch;
      wr_phase   = ph;
      commit_req = r;
   endtask

   task automatic tick();
      check("rdy0", 64'(d0_rdy), 64'(!pend[0]));
      check("rdy1", 64'(d1_rdy), 64'(!pend[1]));
      mstep(0);
      mstep(1);
      @(posedge clk);
      #1;
      ncyc++;
      check_all();
      if (d0_pulse) p0++;
      if (d1_pulse) p1++;
      cnt = cnt + 8'd1;
   endtask

   task automatic idle(input int n);
      drv(0, 7'd0, 8'd0, 0);
      repeat (n) tick();
   endtask

   task automatic run_idle();
      int b;
      b = 0;
      drv(0, 7'd0, 8'd0, 0);
      while ((pend[0] || pend[1]) && b < 2000) begin
         tick();
         b++;
      end
      check("idle_bound", 64'(pend[0] || pend[1]), 64'd0);
   endtask

   initial begin
      int q0, q1, b;
      longint t0;
      rst = 1'b1;
      cnt = 8'd0;
      drv(0, 7'd0, 8'd0, 0);
      mreset();
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // Frame commit at the wrap after a mid-period request.
      drv(1, 7'd0, 8'h10, 0);
      tick();
      drv(1, 7'd127, 8'hF0, 0);
      tick();
      drv(0, 7'd0, 8'd0, 0);
      while (cnt != 8'd100) tick();
      drv(0, 7'd0, 8'd0, 1);
      tick();
      drv(0, 7'd0, 8'd0, 0);
      while (cnt != 8'd255) tick();
      check("A_hold_ch0", 64'(d0_ph[0 +: 8]), 64'h0);
      check("A_hold_ch127", 64'(d0_ph[127*8 +: 8]), 64'h0);
      tick();
      check("A_pulse", 64'(d0_pulse), 64'd1);
      check("A_ch0", 64'(d0_ph[0 +: 8]), 64'h10);
      check("A_ch127", 64'(d0_ph[127*8 +: 8]), 64'hF0);
      check("A_fcnt", 64'(d0_fc), 64'd1);
      tick();
      check("A_once", 64'(d0_pulse), 64'd0);

      // Back-pressure while pending.
      drv(0, 7'd0, 8'd0, 1);
      tick();
      drv(1, 7'd5, 8'h33, 0);
      check("B_rdy_lo", 64'(d0_rdy), 64'd0);
      tick();
      run_idle();
      check("B_rdy_hi", 64'(d0_rdy), 64'd1);
      drv(0, 7'd0, 8'd0, 1);
      tick();
      run_idle();
      check("B_ch5", 64'(d0_ph[5*8 +: 8]), 64'h0);
      check("B_ch0", 64'(d0_ph[0 +: 8]), 64'h10);

      // Overrun: second request three cycles after the first.
      drv(0, 7'd0, 8'd0, 0);
      while (cnt != 8'd20) tick();
      q0 = p0;
      drv(0, 7'd0, 8'd0, 1);
      tick();
      idle(2);
      drv(0, 7'd0, 8'd0, 1);
      tick();
      run_idle();
      idle(2);
      check("C_ovr", 64'(d0_ovr), 64'd1);
      check("C_ovc", 64'(d0_oc), 64'd1);
      check("C_pulses", 64'(p0 - q0), 64'd1);

      // Asynchronous reset between edges while pending.
      drv(0, 7'd0, 8'd0, 1);
      tick();
      idle(2);
      #2 rst = 1'b1;
      #1;
      mreset();
      check_all();
      check("E_pend", 64'(d0_pend), 64'd0);
      check("E_ch0", 64'(d0_ph[0 +: 8]), 64'h0);
      check("E_fcnt", 64'(d0_fc), 64'd0);
      check("E_ovc", 64'(d0_oc), 64'd0);
      #1 rst = 1'b0;
      q0 = p0;
      q1 = p1;
      idle(300);
      check("E_nopulse0", 64'(p0 - q0), 64'd0);
      check("E_nopulse1", 64'(p1 - q1), 64'd0);

      // Holdoff: commit B lands three wraps after commit A.
      drv(0, 7'd0, 8'd0, 1);
      tick();
      b = 0;
      drv(0, 7'd0, 8'd0, 0);
      while (!d1_pulse && b < 1000) begin
         tick();
         b++;
      end
      check("F_first", 64'(d1_pulse), 64'd1);
      t0 = ncyc;
      drv(0, 7'd0, 8'd0, 1);
      tick();
      b = 0;
      drv(0, 7'd0, 8'd0, 0);
      while (!d1_pulse && b < 2000) begin
         tick();
         b++;
      end
      check("F_second", 64'(d1_pulse), 64'd1);
      check("F_gap", 64'(ncyc - t0), 64'd768);

      // Out-of-range channel on the 100-channel instance.
      run_idle();
      drv(1, 7'd120, 8'hAA, 0);
      tick();
      drv(0, 7'd0, 8'd0, 1);
      tick();
      run_idle();
      idle(1);
      check("D_bad1", 64'(d1_bad), 64'd1);
      check("D_bad0", 64'(d0_bad), 64'd0);
      check("D_ch120", 64'(d0_ph[120*8 +: 8]), 64'hAA);

      // Random traffic.
      repeat (3000) begin
         drv(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
             8'($urandom_range(0, 255)), ($urandom_range(0, 99) == 0));
         tick();
      end

      // Overrun counter saturation.
      drv(0, 7'd0, 8'd0, 1);
      repeat (70000) tick();
      idle(1);
      check("S_ovc0", 64'(d0_oc), 64'hFFFF);
      check("S_ovc1", 64'(d1_oc), 64'hFFFF);
      check("S_ovr0", 64'(d0_ovr), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
